// File: rtl/fifo_burst_reader.sv
// Drains a fall-through FIFO into fixed-length valid/ready bursts, flagging the last word of each.
// Latency: start condition at N -> first pop N+1 -> m_valid N+2. m_ready low stalls pops and holds the output word.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_rst,
  output logic                  fifo_ren,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  input  logic [CNT_WIDTH-1:0]  fifo_data_count,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_partial,
  output logic                  burst_active
);

  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] BL_C = CNT_WIDTH'(BURST_LEN);
  localparam logic [IW-1:0]        TO_C = IW'(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [IW-1:0]         idle_cnt_q, idle_cnt_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  logic                  m_partial_q, m_partial_d;
  logic                  hs;

  assign hs = m_valid_q & m_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    idle_cnt_d  = idle_cnt_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    m_partial_d = m_partial_q;
    fifo_ren    = 1'b0;
    case (state_q)
      IDLE: begin
        // Full bursts win over the flush, so a snapshot never equals BURST_LEN.
        if (fifo_data_count >= BL_C) begin
          state_d     = XFER;
          remaining_d = BL_C;
          m_partial_d = 1'b0;
          idle_cnt_d  = '0;
        end else if ((TIMEOUT != 0) && (fifo_data_count != '0) && (idle_cnt_q == TO_C)) begin
          state_d     = XFER;
          remaining_d = fifo_data_count;
          m_partial_d = 1'b1;
          idle_cnt_d  = '0;
        end else if (fifo_data_count == '0) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q != TO_C) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      XFER: begin
        fifo_ren = (remaining_q != '0) & ~fifo_empty & (~m_valid_q | m_ready);
        if (fifo_ren) begin
          m_data_d    = fifo_rdata;
          m_valid_d   = 1'b1;
          m_last_d    = (remaining_q == CNT_WIDTH'(1));
          remaining_d = remaining_q - 1'b1;
        end else if (hs) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
        if (hs & m_last_q) begin
          state_d     = IDLE;
          m_partial_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fifo_clk) begin
    if (fifo_rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      idle_cnt_q  <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      m_partial_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      idle_cnt_q  <= idle_cnt_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      m_partial_q <= m_partial_d;
    end
  end

  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_last       = m_last_q;
  assign m_partial    = m_partial_q;
  assign burst_active = (state_q == XFER);

endmodule
